fft_controller: RTL and testbench

FFT_CONTROLLER -- requirements
Module: fft_controller

---
 rtl/fft_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_fft_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_controller.sv
// Address/strobe sequencer for an in-place radix-2 FFT on a dual-port BRAM:
// bit-reversed load, AW butterfly stages with write-back delay, natural-order unload.
module fft_controller #(
  parameter int N = 256,
  parameter int BF_LAT = 3,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic          dready_i,
  input  logic          dl_busy_i,
  output logic          busy_o,
  output logic          fft_ready_o,
  output logic          fft_done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_x0_o,
  output logic [AW-1:0] rd_addr_x1_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_x0_o,
  output logic [AW-1:0] wr_addr_x1_o,
  output logic          load_sel_o,
  output logic [AW-2:0] twiddle_addr_o,
  output logic [3:0]    state_o
);
  localparam int SW = (AW > 1) ? $clog2(AW) : 1;
  localparam int BW = AW - 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_CNT      = CW'(N);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
  localparam logic [BW-1:0] BF_LAST    = BW'(N / 2 - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(AW - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'(BF_LAT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    COMPUTE = 4'd2,
    DRAIN   = 4'd3,
    UNLOAD  = 4'd4,
    DONE    = 4'd5
  } state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d, out_cnt_q, out_cnt_d;
  logic [BW-1:0] bf_q, bf_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [2:0]    drain_q, drain_d;

  logic          busy_q, busy_d, ready_q, ready_d, done_q, done_d;
  logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d, load_sel_q, load_sel_d;
  logic [AW-1:0] rd_a0_q, rd_a0_d, rd_a1_q, rd_a1_d;
  logic [AW-1:0] wr_a0_q, wr_a0_d, wr_a1_q, wr_a1_d;
  logic [BW-1:0] tw_q, tw_d;

  logic          pipe_v_q  [BF_LAT];
  logic [AW-1:0] pipe_a0_q [BF_LAT];
  logic [AW-1:0] pipe_a1_q [BF_LAT];

  logic          cmp_issue;
  logic [AW-1:0] bf_ext, span, pos, cmp_a0, cmp_a1, load_rev;
  logic [BW-1:0] cmp_tw;

  // Butterfly pair addressing for the current (stage, bf) and bit-reversed load address.
  always_comb begin
    bf_ext = {1'b0, bf_q};
    span   = AW'(1) << stage_q;
    pos    = bf_ext & (span - AW'(1));
    cmp_a0 = (((bf_ext >> stage_q) << stage_q) << 1) | pos;
    cmp_a1 = cmp_a0 + span;
    cmp_tw = BW'(pos << (STAGE_LAST - stage_q));
    for (int i = 0; i < AW; i++) load_rev[i] = load_cnt_q[AW-1-i];
  end

  // dready_i and dl_busy_i are sampled on every rising edge: a LOAD write (or UNLOAD read)
  // is issued on the edge where dready_i=1 (dl_busy_i=0) and shows on the outputs next cycle.
  always_comb begin
    state_d    = state_q;
    armed_d    = start_i ? armed_q : 1'b1;
    load_cnt_d = load_cnt_q;
    out_cnt_d  = out_cnt_q;
    bf_d       = bf_q;
    stage_d    = stage_q;
    drain_d    = drain_q;
    ready_d    = rd_en_q && (state_q == UNLOAD);
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_a0_d    = '0;
    rd_a1_d    = '0;
    tw_d       = '0;
    wr_en_d    = pipe_v_q[BF_LAT-1];
    wr_a0_d    = pipe_a0_q[BF_LAT-1];
    wr_a1_d    = pipe_a1_q[BF_LAT-1];
    load_sel_d = 1'b0;
    cmp_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && armed_q) begin
          state_d    = LOAD;
          armed_d    = 1'b0;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (dready_i) begin
          wr_en_d    = 1'b1;
          wr_a0_d    = load_rev;
          wr_a1_d    = '0;
          load_sel_d = 1'b1;
          load_cnt_d = load_cnt_q + CW'(1);
          if (load_cnt_q == LOAD_LAST) begin
            state_d = COMPUTE;
            stage_d = '0;
            bf_d    = '0;
          end
        end
      end
      COMPUTE: begin
        rd_en_d   = 1'b1;
        rd_a0_d   = cmp_a0;
        rd_a1_d   = cmp_a1;
        tw_d      = cmp_tw;
        cmp_issue = 1'b1;
        if (bf_q == BF_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          bf_d = bf_q + BW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d   = UNLOAD;
            out_cnt_d = '0;
          end else begin
            state_d = COMPUTE;
            stage_d = stage_q + SW'(1);
            bf_d    = '0;
          end
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      UNLOAD: begin
        if (!dl_busy_i && out_cnt_q < N_CNT) begin
          rd_en_d   = 1'b1;
          rd_a0_d   = out_cnt_q[AW-1:0];
          out_cnt_d = out_cnt_q + CW'(1);
        end
        // Leave once the last sample has been presented and nothing is still in flight.
        if (out_cnt_q == N_CNT && ready_q && !rd_en_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      load_cnt_q <= '0;
      out_cnt_q  <= '0;
      bf_q       <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_a0_q    <= '0;
      rd_a1_q    <= '0;
      tw_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_a0_q    <= '0;
      wr_a1_q    <= '0;
      load_sel_q <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) begin
        pipe_v_q[i]  <= 1'b0;
        pipe_a0_q[i] <= '0;
        pipe_a1_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q  <= out_cnt_d;
      bf_q       <= bf_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_a0_q    <= rd_a0_d;
      rd_a1_q    <= rd_a1_d;
      tw_q       <= tw_d;
      wr_en_q    <= wr_en_d;
      wr_a0_q    <= wr_a0_d;
      wr_a1_q    <= wr_a1_d;
      load_sel_q <= load_sel_d;
      // pipe slot 0 is aligned with rd_en_o; the write strobe is registered from the last slot.
      pipe_v_q[0]  <= cmp_issue;
      pipe_a0_q[0] <= cmp_a0;
      pipe_a1_q[0] <= cmp_a1;
      for (int i = 1; i < BF_LAT; i++) begin
        pipe_v_q[i]  <= pipe_v_q[i-1];
        pipe_a0_q[i] <= pipe_a0_q[i-1];
        pipe_a1_q[i] <= pipe_a1_q[i-1];
      end
    end
  end

  assign state_o        = state_q;
  assign busy_o         = busy_q;
  assign fft_ready_o    = ready_q;
  assign fft_done_o     = done_q;
  assign rd_en_o        = rd_en_q;
  assign rd_addr_x0_o   = rd_a0_q;
  assign rd_addr_x1_o   = rd_a1_q;
  assign twiddle_addr_o = tw_q;
  assign wr_en_o        = wr_en_q;
  assign wr_addr_x0_o   = wr_a0_q;
  assign wr_addr_x1_o   = wr_a1_q;
  assign load_sel_o     = load_sel_q;
endmodule

// File: tb/tb_fft_controller.sv
// Directed bench for fft_controller (N=256, BF_LAT=3): full frames with load/unload
// stalls, held start, and an asynchronous mid-compute abort.
module tb_fft_controller;
  localparam int N = 256;
  localparam int AW = 8;
  localparam int BF_LAT = 3;

  logic clk = 1'b0;
  logic rstn, start_i, dready_i, dl_busy_i;
  logic busy_o, fft_ready_o, fft_done_o, rd_en_o, wr_en_o, load_sel_o;
  logic [AW-1:0] rd_addr_x0_o, rd_addr_x1_o, wr_addr_x0_o, wr_addr_x1_o;
  logic [AW-2:0] twiddle_addr_o;
  logic [3:0] state_o;
  logic [48:0] all_out;

  int checks = 0;
  int failures = 0;

  fft_controller #(.N(N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .dready_i(dready_i), .dl_busy_i(dl_busy_i),
    .busy_o(busy_o), .fft_ready_o(fft_ready_o), .fft_done_o(fft_done_o),
    .rd_en_o(rd_en_o), .rd_addr_x0_o(rd_addr_x0_o), .rd_addr_x1_o(rd_addr_x1_o),
    .wr_en_o(wr_en_o), .wr_addr_x0_o(wr_addr_x0_o), .wr_addr_x1_o(wr_addr_x1_o),
    .load_sel_o(load_sel_o), .twiddle_addr_o(twiddle_addr_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign all_out = {busy_o, fft_ready_o, fft_done_o, rd_en_o, rd_addr_x0_o, rd_addr_x1_o,
                    wr_en_o, wr_addr_x0_o, wr_addr_x1_o, load_sel_o, twiddle_addr_o, state_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) if (v[i]) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; dready_i = 1'b0; dl_busy_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (state_o !== 4'd0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle state=%0d busy=%b exp state=0 busy=0", state_o, busy_o);
    end
  endtask

  task automatic test_load(input int gap_at, input int gap_len);
    int issued, writes, cyc, low;
    logic drv;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] first_tab [4];
    first_tab = '{8'd0, 8'd128, 8'd64, 8'd192};
    start_i = 1'b1; dready_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 4'd1 || busy_o !== 1'b1) begin
      failures++; $display("FAIL load_entry state=%0d busy=%b exp state=1 busy=1", state_o, busy_o);
    end
    issued = 0; writes = 0; cyc = 0; low = 0;
    while (writes < N && cyc < 1000) begin
      drv = (issued < N) && !(cyc >= gap_at && cyc < gap_at + gap_len);
      dready_i = drv;
      if (drv) issued++;
      tick();
      cyc++;
      checks++;
      if (wr_en_o !== drv) begin
        failures++; $display("FAIL load_wr_en cyc=%0d got=%b exp=%b", cyc, wr_en_o, drv);
      end
      if (wr_en_o !== 1'b1) low++;
      if (wr_en_o === 1'b1) begin
        exp_a = AW'(bitrev(writes));
        checks++;
        if (wr_addr_x0_o !== exp_a || load_sel_o !== 1'b1) begin
          failures++;
          $display("FAIL load_addr n=%0d got=%0d sel=%b exp=%0d sel=1", writes, wr_addr_x0_o, load_sel_o, exp_a);
        end
        if (writes < 4) begin
          checks++;
          if (wr_addr_x0_o !== first_tab[writes]) begin
            failures++; $display("FAIL load_addr_table n=%0d got=%0d exp=%0d", writes, wr_addr_x0_o, first_tab[writes]);
          end
        end
        writes++;
      end
    end
    dready_i = 1'b0;
    checks++;
    if (writes != N) begin
      failures++; $display("FAIL load_count got=%0d exp=%0d", writes, N);
    end
    checks++;
    if (low != gap_len) begin
      failures++; $display("FAIL load_stall_cycles got=%0d exp=%0d", low, gap_len);
    end
    checks++;
    if (state_o !== 4'd2) begin
      failures++; $display("FAIL load_exit state=%0d exp=2", state_o);
    end
  endtask

  task automatic test_compute();
    int cyc, idx, total, k;
    logic h_en [$];
    logic [AW-1:0] h_a0 [$];
    logic [AW-1:0] h_a1 [$];
    logic [AW-1:0] e0 [$];
    logic [AW-1:0] e1 [$];
    logic [AW-2:0] et [$];
    logic [AW-1:0] x0, x1;
    logic [AW-2:0] xt;
    for (int s = 0; s < AW; s++) begin
      for (int g = 0; g < N; g += 2 << s) begin
        for (int p = 0; p < (1 << s); p++) begin
          e0.push_back(AW'(g + p));
          e1.push_back(AW'(g + p + (1 << s)));
          et.push_back((AW-1)'(p * (N / (2 << s))));
        end
      end
    end
    cyc = 0; idx = 0; total = 1;
    while (cyc < 2000) begin
      dready_i = cyc[0];
      dl_busy_i = cyc[1];
      tick();
      checks++;
      if (cyc >= BF_LAT) begin
        k = cyc - BF_LAT;
        if (wr_en_o !== h_en[k] || load_sel_o !== 1'b0 ||
            (h_en[k] && (wr_addr_x0_o !== h_a0[k] || wr_addr_x1_o !== h_a1[k]))) begin
          failures++;
          $display("FAIL writeback cyc=%0d got en=%b %0d/%0d exp en=%b %0d/%0d", cyc, wr_en_o,
                   wr_addr_x0_o, wr_addr_x1_o, h_en[k], h_a0[k], h_a1[k]);
        end
      end else if (wr_en_o !== 1'b0) begin
        failures++; $display("FAIL writeback_early cyc=%0d got=%b exp=0", cyc, wr_en_o);
      end
      h_en.push_back(rd_en_o); h_a0.push_back(rd_addr_x0_o); h_a1.push_back(rd_addr_x1_o);
      cyc++;
      if (state_o === 4'd4) break;
      total++;
      if (rd_en_o === 1'b1) begin
        checks++;
        if (e0.size() == 0) begin
          failures++; $display("FAIL compute_extra_read got=%0d exp=none", rd_addr_x0_o);
        end else begin
          x0 = e0.pop_front(); x1 = e1.pop_front(); xt = et.pop_front();
          if (rd_addr_x0_o !== x0 || rd_addr_x1_o !== x1 || twiddle_addr_o !== xt) begin
            failures++;
            $display("FAIL compute_read n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", idx,
                     rd_addr_x0_o, rd_addr_x1_o, twiddle_addr_o, x0, x1, xt);
          end
          if (idx == 1) begin
            checks++;
            if (rd_addr_x0_o !== 8'd2 || rd_addr_x1_o !== 8'd3 || twiddle_addr_o !== 7'd0) begin
              failures++;
              $display("FAIL s0_bf1 got=%0d/%0d/%0d exp=2/3/0", rd_addr_x0_o, rd_addr_x1_o, twiddle_addr_o);
            end
          end
          if (idx == 7 * (N / 2) + 5) begin
            checks++;
            if (rd_addr_x0_o !== 8'd5 || rd_addr_x1_o !== 8'd133 || twiddle_addr_o !== 7'd5) begin
              failures++;
              $display("FAIL s7_bf5 got=%0d/%0d/%0d exp=5/133/5", rd_addr_x0_o, rd_addr_x1_o, twiddle_addr_o);
            end
          end
        end
        idx++;
      end
    end
    dready_i = 1'b0; dl_busy_i = 1'b0;
    checks++;
    if (state_o !== 4'd4) begin
      failures++; $display("FAIL compute_timeout state=%0d exp=4", state_o);
    end
    checks++;
    if (idx != AW * N / 2 || e0.size() != 0) begin
      failures++; $display("FAIL compute_reads got=%0d exp=%0d", idx, AW * N / 2);
    end
    checks++;
    if (total != AW * (N / 2 + BF_LAT)) begin
      failures++; $display("FAIL compute_cycles got=%0d exp=%0d", total, AW * (N / 2 + BF_LAT));
    end
  endtask

  task automatic test_unload(input int gap_at, input int gap_len);
    int issued, readies, cyc, gap_low;
    logic nxt_rd, exp_rd, exp_ready;
    issued = 0; readies = 0; cyc = 0; gap_low = 0; exp_rd = 1'b0;
    while (readies < N && cyc < 2000) begin
      dl_busy_i = (cyc >= gap_at && cyc < gap_at + gap_len);
      nxt_rd = !dl_busy_i && issued < N;
      tick();
      cyc++;
      exp_ready = exp_rd;
      exp_rd = nxt_rd;
      checks++;
      if (rd_en_o !== exp_rd || (exp_rd && rd_addr_x0_o !== AW'(issued))) begin
        failures++;
        $display("FAIL unload_read cyc=%0d got en=%b addr=%0d exp en=%b addr=%0d", cyc, rd_en_o, rd_addr_x0_o, exp_rd, issued);
      end
      if (exp_rd) issued++;
      checks++;
      if (fft_ready_o !== exp_ready || fft_done_o !== 1'b0 || wr_en_o !== 1'b0) begin
        failures++;
        $display("FAIL unload_ready cyc=%0d got rdy=%b done=%b wr=%b exp rdy=%b done=0 wr=0", cyc,
                 fft_ready_o, fft_done_o, wr_en_o, exp_ready);
      end
      if (fft_ready_o === 1'b1) readies++;
      else if (readies > 0) gap_low++;
    end
    dl_busy_i = 1'b0;
    checks++;
    if (readies != N) begin
      failures++; $display("FAIL unload_count got=%0d exp=%0d", readies, N);
    end
    checks++;
    if (gap_low != gap_len) begin
      failures++; $display("FAIL unload_gap got=%0d exp=%0d", gap_low, gap_len);
    end
    tick();
    checks++;
    if (state_o !== 4'd5 || fft_done_o !== 1'b1 || busy_o !== 1'b1 || rd_en_o !== 1'b0 || wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got state=%0d done=%b busy=%b rd=%b wr=%b exp 5/1/1/0/0", state_o,
               fft_done_o, busy_o, rd_en_o, wr_en_o);
    end
    tick();
    checks++;
    if (state_o !== 4'd0 || fft_done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL done_exit got state=%0d done=%b busy=%b exp 0/0/0", state_o, fft_done_o, busy_o);
    end
  endtask

  task automatic test_hold_start();
    int bad;
    bad = 0;
    start_i = 1'b1;
    repeat (6) begin
      tick();
      if (state_o !== 4'd0 || busy_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL held_start_retrigger got=%0d busy cycles exp=0", bad);
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 4'd0) begin
      failures++; $display("FAIL rearm_idle state=%0d exp=0", state_o);
    end
  endtask

  task automatic test_abort();
    int trans, cyc, done_seen;
    logic [3:0] prev;
    test_load(0, 0);
    trans = 0; cyc = 0; prev = state_o;
    while (trans < 4 && cyc < 2000) begin
      tick();
      if (prev === 4'd3 && state_o === 4'd2) trans++;
      prev = state_o;
      cyc++;
    end
    repeat (10) tick();
    checks++;
    if (state_o !== 4'd2 || rd_en_o !== 1'b1) begin
      failures++; $display("FAIL abort_setup got state=%0d rd=%b exp 2/1", state_o, rd_en_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL abort_async got=%h exp=0", all_out);
    end
    done_seen = 0;
    repeat (3) begin
      tick();
      if (fft_done_o !== 1'b0 || all_out !== '0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL abort_hold got=%0d nonzero cycles exp=0", done_seen);
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load(0, 0);
    test_compute();
    test_unload(0, 0);
    test_hold_start();
    test_load(100, 30);
    test_compute();
    test_unload(50, 10);
    start_i = 1'b0;
    tick();
    test_abort();
    test_load(0, 0);
    test_compute();
    test_unload(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
